// File: rtl/i8bit_div_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered quotient and remainder.
module i8bit_div_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] div_ip_A,
    input  logic [7:0] div_ip_B,
    output logic       busy,
    output logic       done,
    output logic [7:0] quot,
    output logic [7:0] rem,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [8:0] r_part;
    logic [7:0] r_q_sh;
    logic [7:0] r_div;
    logic [2:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_quot;
    logic [7:0] r_rem;
    logic       r_dbz;

    logic [8:0] w_trial;
    logic       w_fits;
    logic [8:0] w_part_next;
    logic [7:0] w_q_next;

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    assign w_trial     = {r_part[7:0], r_q_sh[7]};
    assign w_fits      = (w_trial >= {1'b0, r_div});
    assign w_part_next = w_fits ? (w_trial - {1'b0, r_div}) : w_trial;
    assign w_q_next    = {r_q_sh[6:0], w_fits};

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_part  <= '0;
            r_q_sh  <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_part <= '0;
                        r_q_sh <= div_ip_A;
                        r_div  <= div_ip_B;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (div_ip_B == 8'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_quot  <= 8'hFF;
                            r_rem   <= div_ip_A;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end

                ST_CALC: begin
                    r_part <= w_part_next;
                    r_q_sh <= w_q_next;
                    r_cnt  <= r_cnt + 3'd1;
                    // Results come straight from the final step so DONE needs no extra cycle.
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_quot  <= w_q_next;
                        r_rem   <= w_part_next[7:0];
                        r_dbz   <= 1'b0;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_i8bit_div_seq.sv
// Self-checking bench for i8bit_div_seq: directed corner cases plus a
// randomized back-to-back sweep against an arithmetic reference model.
module tb_i8bit_div_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] div_ip_A = '0;
    logic [7:0] div_ip_B = '0;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    localparam int SWEEP_OPS   = 2000;
    localparam int SWEEP_LIMIT = 40000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    i8bit_div_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .div_ip_A   (div_ip_A),
        .div_ip_B   (div_ip_B),
        .busy       (busy),
        .done       (done),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_quot(input int a, input int b);
        return (b == 0) ? 255 : a / b;
    endfunction

    function automatic int ref_rem(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Issue one start, verify busy and held results until done, then latency and results.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input bit chk_hold, input int hold_q, input int hold_r);
        int lat;
        @(negedge clk);
        div_ip_A = a;
        div_ip_B = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        div_ip_A = 8'hA5;
        div_ip_B = 8'h5A;
        lat = 0;
        while (!done && lat < 20) begin
            check({tag, "_busy"}, int'(busy), 1);
            if (chk_hold) begin
                check({tag, "_hold_q"}, int'(quot), hold_q);
                check({tag, "_hold_r"}, int'(rem), hold_r);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, (b == 0) ? 0 : 8);
        check({tag, "_busy_at_done"}, int'(busy), 1);
        check({tag, "_quot"}, int'(quot), ref_quot(a, b));
        check({tag, "_rem"}, int'(rem), ref_rem(a, b));
        check({tag, "_dbz"}, int'(div_by_zero), (b == 0) ? 1 : 0);
        @(negedge clk);
        check({tag, "_done_single"}, int'(done), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int n_done;
        int seen_q;
        int seen_r;
        op_t pend[$];
        op_t cur;
        op_t got;
        int accepted;
        int dones;
        int cyc;
        bit prev_busy;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quot", int'(quot), 0);
        check("rst_rem", int'(rem), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;

        run_op("basic_200_7", 8'd200, 8'd7, 1'b1, 0, 0);
        run_op("b_255_1", 8'd255, 8'd1, 1'b0, 0, 0);
        run_op("b_5_9", 8'd5, 8'd9, 1'b0, 0, 0);
        run_op("b_0_3", 8'd0, 8'd3, 1'b0, 0, 0);
        run_op("b_255_255", 8'd255, 8'd255, 1'b0, 0, 0);
        run_op("dz_37_0", 8'd37, 8'd0, 1'b0, 0, 0);
        run_op("after_dz_10_3", 8'd10, 8'd3, 1'b1, 255, 37);

        // A start during CALC must be ignored and must not queue a second operation.
        @(negedge clk);
        div_ip_A = 8'd200;
        div_ip_B = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        div_ip_A = 8'd100;
        div_ip_B = 8'd10;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        seen_q = -1;
        seen_r = -1;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                n_done++;
                seen_q = int'(quot);
                seen_r = int'(rem);
            end
            @(negedge clk);
        end
        check("busy_start_done_count", n_done, 1);
        check("busy_start_quot", seen_q, 28);
        check("busy_start_rem", seen_r, 4);
        run_op("hold_then_9_2", 8'd9, 8'd2, 1'b1, 28, 4);

        // Reset in the middle of CALC: no done, everything cleared.
        @(negedge clk);
        div_ip_A = 8'd200;
        div_ip_B = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_quot", int'(quot), 0);
        check("midrst_rem", int'(rem), 0);
        check("midrst_dbz", int'(div_by_zero), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        rst_n = 1'b1;
        run_op("post_rst_9_2", 8'd9, 8'd2, 1'b0, 0, 0);

        // Randomized sweep with start held high: every IDLE visit starts a new operation.
        accepted  = 0;
        dones     = 0;
        cyc       = 0;
        prev_busy = 1'b0;
        @(negedge clk);
        cur.a    = 8'($urandom_range(0, 255));
        cur.b    = 8'($urandom_range(0, 255));
        div_ip_A = cur.a;
        div_ip_B = cur.b;
        start    = 1'b1;
        while ((accepted < SWEEP_OPS || pend.size() != 0) && cyc < SWEEP_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
                pend.push_back(cur);
                accepted++;
                if (accepted == SWEEP_OPS) start = 1'b0;
                cur.a = 8'($urandom_range(0, 255));
                cur.b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                div_ip_A = cur.a;
                div_ip_B = cur.b;
            end
            if (done) begin
                dones++;
                if (pend.size() == 0) begin
                    check("sweep_spurious_done", 1, 0);
                end else begin
                    got = pend.pop_front();
                    check("sweep_quot", int'(quot), ref_quot(int'(got.a), int'(got.b)));
                    check("sweep_rem", int'(rem), ref_rem(int'(got.a), int'(got.b)));
                    check("sweep_dbz", int'(div_by_zero), (got.b == 0) ? 1 : 0);
                    if (got.b != 0) begin
                        check("sweep_invariant", int'(quot) * int'(got.b) + int'(rem), int'(got.a));
                        check("sweep_rem_lt_div", int'(rem < got.b), 1);
                    end
                end
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("sweep_timeout", int'(cyc < SWEEP_LIMIT), 1);
        check("sweep_done_count", dones, accepted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
